// File: rtl/sram_port0_arbiter.sv
// Port-0 controller for the 32x256 single-clock SRAM macro: optional post-reset clear sweep,
// round-robin arbitration of two requesters, fixed 3-cycle read return, port 1 tied off.
module sram_port0_arbiter #(
  parameter int ADDR_WIDTH     = 8,
  parameter int DATA_WIDTH     = 32,
  parameter int NUM_WMASKS     = 4,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic                  clk,
  input  logic                  reset,

  input  logic                  m0_req,
  input  logic                  m0_we,
  input  logic [NUM_WMASKS-1:0] m0_wmask,
  input  logic [ADDR_WIDTH-1:0] m0_addr,
  input  logic [DATA_WIDTH-1:0] m0_wdata,
  output logic                  m0_gnt,
  output logic                  m0_rvalid,
  output logic [DATA_WIDTH-1:0] m0_rdata,

  input  logic                  m1_req,
  input  logic                  m1_we,
  input  logic [NUM_WMASKS-1:0] m1_wmask,
  input  logic [ADDR_WIDTH-1:0] m1_addr,
  input  logic [DATA_WIDTH-1:0] m1_wdata,
  output logic                  m1_gnt,
  output logic                  m1_rvalid,
  output logic [DATA_WIDTH-1:0] m1_rdata,

  output logic                  init_done,

  output logic                  sram_csb0,
  output logic                  sram_web0,
  output logic [NUM_WMASKS-1:0] sram_wmask0,
  output logic [ADDR_WIDTH-1:0] sram_addr0,
  output logic [DATA_WIDTH-1:0] sram_din0,
  input  logic [DATA_WIDTH-1:0] sram_dout0,

  output logic                  sram_csb1,
  output logic [ADDR_WIDTH-1:0] sram_addr1
);

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t                  state_reg, state_next;
  logic [ADDR_WIDTH-1:0]   clr_addr_reg, clr_addr_next;
  logic                    init_done_reg;
  logic                    rr_reg;          // 0: m0 wins a tie, 1: m1 wins a tie
  logic                    rr_next;

  logic [1:0]              req_vec;
  logic [1:0]              gnt_vec;
  logic                    gnt_any;
  logic                    gnt_id;

  logic                    sel_we;
  logic [NUM_WMASKS-1:0]   sel_wmask;
  logic [ADDR_WIDTH-1:0]   sel_addr;
  logic [DATA_WIDTH-1:0]   sel_wdata;

  logic                    csb0_reg, csb0_next;
  logic                    web0_reg, web0_next;
  logic [NUM_WMASKS-1:0]   wmask0_reg, wmask0_next;
  logic [ADDR_WIDTH-1:0]   addr0_reg, addr0_next;
  logic [DATA_WIDTH-1:0]   din0_reg, din0_next;

  logic [1:0]              rd_vld_reg;
  logic [1:0]              rd_id_reg;
  logic [1:0]              rvalid_reg;
  logic [DATA_WIDTH-1:0]   rdata_reg [2];

  assign req_vec = {m1_req, m0_req};

  // Grants wait for init_done so the clear sweep owns the port exclusively.
  always_comb begin
    gnt_vec = 2'b00;
    if (init_done_reg && !reset) begin
      if (req_vec[0] && (!req_vec[1] || !rr_reg))
        gnt_vec[0] = 1'b1;
      else if (req_vec[1])
        gnt_vec[1] = 1'b1;
    end
  end

  assign gnt_any = |gnt_vec;
  assign gnt_id  = gnt_vec[1];

  always_comb begin
    rr_next = rr_reg;
    if (gnt_vec[0])
      rr_next = 1'b1;
    else if (gnt_vec[1])
      rr_next = 1'b0;
  end

  assign sel_we    = gnt_id ? m1_we    : m0_we;
  assign sel_wmask = gnt_id ? m1_wmask : m0_wmask;
  assign sel_addr  = gnt_id ? m1_addr  : m0_addr;
  assign sel_wdata = gnt_id ? m1_wdata : m0_wdata;

  always_comb begin
    state_next    = state_reg;
    clr_addr_next = clr_addr_reg;
    case (state_reg)
      ST_INIT: begin
        clr_addr_next = clr_addr_reg + 1'b1;
        if (clr_addr_reg == {ADDR_WIDTH{1'b1}})
          state_next = ST_RUN;
      end
      ST_RUN:  state_next = ST_RUN;
      default: state_next = ST_INIT;
    endcase
  end

  // Idle cycles deselect the macro but leave address/data lines where they were.
  always_comb begin
    csb0_next   = 1'b1;
    web0_next   = 1'b1;
    wmask0_next = '0;
    addr0_next  = addr0_reg;
    din0_next   = din0_reg;
    if (state_reg == ST_INIT) begin
      csb0_next   = 1'b0;
      web0_next   = 1'b0;
      wmask0_next = {NUM_WMASKS{1'b1}};
      addr0_next  = clr_addr_reg;
      din0_next   = '0;
    end else if (gnt_any) begin
      csb0_next   = 1'b0;
      web0_next   = ~sel_we;
      wmask0_next = sel_we ? sel_wmask : '0;
      addr0_next  = sel_addr;
      din0_next   = sel_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= (CLEAR_ON_RESET != 0) ? ST_INIT : ST_RUN;
      clr_addr_reg  <= '0;
      init_done_reg <= 1'b0;
      rr_reg        <= 1'b0;
      csb0_reg      <= 1'b1;
      web0_reg      <= 1'b1;
      wmask0_reg    <= '0;
      addr0_reg     <= '0;
      din0_reg      <= '0;
      rd_vld_reg    <= 2'b00;
      rd_id_reg     <= 2'b00;
    end else begin
      state_reg     <= state_next;
      clr_addr_reg  <= clr_addr_next;
      init_done_reg <= (state_next == ST_RUN);
      rr_reg        <= rr_next;
      csb0_reg      <= csb0_next;
      web0_reg      <= web0_next;
      wmask0_reg    <= wmask0_next;
      addr0_reg     <= addr0_next;
      din0_reg      <= din0_next;
      // Stage 0 lines up with the command on the pins, stage 1 with dout0 becoming valid.
      rd_vld_reg    <= {rd_vld_reg[0], gnt_any & ~sel_we};
      rd_id_reg     <= {rd_id_reg[0], gnt_id};
    end
  end

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_ret
      always_ff @(posedge clk) begin
        if (reset) begin
          rvalid_reg[gi] <= 1'b0;
          rdata_reg[gi]  <= '0;
        end else begin
          rvalid_reg[gi] <= rd_vld_reg[1] && (rd_id_reg[1] == 1'(gi));
          if (rd_vld_reg[1] && (rd_id_reg[1] == 1'(gi)))
            rdata_reg[gi] <= sram_dout0;
        end
      end
    end
  endgenerate

  assign m0_gnt      = gnt_vec[0];
  assign m1_gnt      = gnt_vec[1];
  assign m0_rvalid   = rvalid_reg[0];
  assign m1_rvalid   = rvalid_reg[1];
  assign m0_rdata    = rdata_reg[0];
  assign m1_rdata    = rdata_reg[1];
  assign init_done   = init_done_reg;

  assign sram_csb0   = csb0_reg;
  assign sram_web0   = web0_reg;
  assign sram_wmask0 = wmask0_reg;
  assign sram_addr0  = addr0_reg;
  assign sram_din0   = din0_reg;

  assign sram_csb1   = 1'b1;
  assign sram_addr1  = '0;

endmodule

// File: tb/tb_sram_port0_arbiter.sv
// Scoreboard bench for sram_port0_arbiter with a behavioural SRAM (posedge input latch,
// negedge write/read) and a second instance built without the clear sweep.
module tb_sram_port0_arbiter;
  localparam int AW = 8;
  localparam int DW = 32;
  localparam int MW = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset = 1'b1;
  logic          m0_req = 0, m0_we = 0, m1_req = 0, m1_we = 0;
  logic [MW-1:0] m0_wmask = '0, m1_wmask = '0;
  logic [AW-1:0] m0_addr = '0, m1_addr = '0;
  logic [DW-1:0] m0_wdata = '0, m1_wdata = '0;
  logic          m0_gnt, m0_rvalid, m1_gnt, m1_rvalid, init_done;
  logic [DW-1:0] m0_rdata, m1_rdata;
  logic          sram_csb0, sram_web0, sram_csb1;
  logic [MW-1:0] sram_wmask0;
  logic [AW-1:0] sram_addr0, sram_addr1;
  logic [DW-1:0] sram_din0, sram_dout0;

  logic          nc_reset = 1'b1;
  logic          nc_m0_req = 1'b0;
  logic          nc_m0_gnt, nc_m0_rvalid, nc_m1_gnt, nc_m1_rvalid, nc_init_done;
  logic [DW-1:0] nc_m0_rdata, nc_m1_rdata, nc_din0;
  logic          nc_csb0, nc_web0, nc_csb1;
  logic [MW-1:0] nc_wmask0;
  logic [AW-1:0] nc_addr0, nc_addr1;

  sram_port0_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_WMASKS(MW), .CLEAR_ON_RESET(1)) dut (
    .clk(clk), .reset(reset),
    .m0_req(m0_req), .m0_we(m0_we), .m0_wmask(m0_wmask), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_wmask(m1_wmask), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
    .init_done(init_done),
    .sram_csb0(sram_csb0), .sram_web0(sram_web0), .sram_wmask0(sram_wmask0),
    .sram_addr0(sram_addr0), .sram_din0(sram_din0), .sram_dout0(sram_dout0),
    .sram_csb1(sram_csb1), .sram_addr1(sram_addr1)
  );

  sram_port0_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_WMASKS(MW), .CLEAR_ON_RESET(0)) dut_nc (
    .clk(clk), .reset(nc_reset),
    .m0_req(nc_m0_req), .m0_we(1'b0), .m0_wmask(4'h0), .m0_addr(8'h00), .m0_wdata(32'h0),
    .m0_gnt(nc_m0_gnt), .m0_rvalid(nc_m0_rvalid), .m0_rdata(nc_m0_rdata),
    .m1_req(1'b0), .m1_we(1'b0), .m1_wmask(4'h0), .m1_addr(8'h00), .m1_wdata(32'h0),
    .m1_gnt(nc_m1_gnt), .m1_rvalid(nc_m1_rvalid), .m1_rdata(nc_m1_rdata),
    .init_done(nc_init_done),
    .sram_csb0(nc_csb0), .sram_web0(nc_web0), .sram_wmask0(nc_wmask0),
    .sram_addr0(nc_addr0), .sram_din0(nc_din0), .sram_dout0(32'h0),
    .sram_csb1(nc_csb1), .sram_addr1(nc_addr1)
  );

  // Behavioural macro: inputs latched on posedge, array access on the following negedge.
  logic [DW-1:0] mem [256];
  logic          csb_l = 1'b1, web_l = 1'b1;
  logic [MW-1:0] wm_l = '0;
  logic [AW-1:0] a_l = '0;
  logic [DW-1:0] d_l = '0;
  logic [DW-1:0] dout = '0;
  assign sram_dout0 = dout;

  initial for (int i = 0; i < 256; i++) mem[i] = 32'hA5A5A5A5;

  always @(posedge clk) begin
    csb_l <= sram_csb0; web_l <= sram_web0; wm_l <= sram_wmask0; a_l <= sram_addr0; d_l <= sram_din0;
  end

  always @(negedge clk) begin
    if (!csb_l) begin
      if (!web_l) begin
        for (int b = 0; b < MW; b++)
          if (wm_l[b]) mem[a_l][8*b +: 8] <= d_l[8*b +: 8];
      end else begin
        dout <= mem[a_l];
      end
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int          id;
    logic [31:0] data;
    int          due;
  } exp_t;
  exp_t sb_q [$];

  // Monitor: every rvalid must match the oldest outstanding read, on its due cycle.
  always @(negedge clk) begin : monitor
    exp_t        e;
    int          act_id;
    logic [31:0] act_data;
    if (m0_rvalid || m1_rvalid) begin
      checks++;
      act_id   = m1_rvalid ? 1 : 0;
      act_data = m1_rvalid ? m1_rdata : m0_rdata;
      if (sb_q.size() == 0) begin
        errors++;
        $display("FAIL rvalid_unexpected actual m0_rvalid=%0b m1_rvalid=%0b data=%h cycle=%0d required no rvalid",
                 m0_rvalid, m1_rvalid, act_data, cyc);
      end else begin
        e = sb_q.pop_front();
        if ((m0_rvalid && m1_rvalid) || act_id != e.id || act_data !== e.data || cyc != e.due) begin
          errors++;
          $display("FAIL rdata actual m%0d data=%h cycle=%0d both=%0b required m%0d data=%h cycle=%0d",
                   act_id, act_data, cyc, m0_rvalid && m1_rvalid, e.id, e.data, e.due);
        end else begin
          $display("READ  m%0d data=%h cycle=%0d", act_id, act_data, cyc);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic set_cmd(input int m, input logic req, input logic we, input logic [3:0] mask,
                         input logic [7:0] addr, input logic [31:0] data);
    if (m == 0) begin
      m0_req = req; m0_we = we; m0_wmask = mask; m0_addr = addr; m0_wdata = data;
    end else begin
      m1_req = req; m1_we = we; m1_wmask = mask; m1_addr = addr; m1_wdata = data;
    end
  endtask

  // Called at a negedge; returns at the negedge after the grant with req dropped.
  task automatic req1(input int m, input logic we, input logic [3:0] mask, input logic [7:0] addr,
                      input logic [31:0] data, input logic [31:0] exp_rd);
    bit got = 0;
    set_cmd(m, 1'b1, we, mask, addr, data);
    for (int i = 0; i < 20 && !got; i++) begin
      #1;
      if ((m == 0) ? m0_gnt : m1_gnt) begin
        got = 1;
        if (!we) sb_q.push_back('{m, exp_rd, cyc + 3});
      end
      @(negedge clk);
    end
    if (m == 0) m0_req = 1'b0; else m1_req = 1'b0;
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL gnt_timeout m%0d actual no gnt in 20 cycles required gnt", m);
    end else begin
      $display("CMD   m%0d %s addr=%h data=%h mask=%h", m, we ? "WR" : "RD", addr, data, mask);
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 12 && sb_q.size() != 0; i++) @(negedge clk);
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL rvalid_missing actual %0d reads outstanding required 0", sb_q.size());
      sb_q.delete();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual timeout required $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int gnt_early;
    int exp_m;
    set_cmd(0, 1'b1, 1'b0, 4'h0, 8'h10, 32'h0);
    nc_m0_req = 1'b1;
    repeat (3) @(negedge clk);

    chk("rst_csb0", sram_csb0, 1'b1);
    chk("rst_web0", sram_web0, 1'b1);
    chk("rst_wmask0", sram_wmask0, 4'h0);
    chk("rst_addr0", sram_addr0, 8'h00);
    chk("rst_din0", sram_din0, 32'h0);
    chk("rst_gnt", {m0_gnt, m1_gnt, m0_rvalid, m1_rvalid}, 4'b0000);
    chk("rst_rdata0", m0_rdata, 32'h0);
    chk("rst_rdata1", m1_rdata, 32'h0);
    chk("rst_init_done", init_done, 1'b0);
    chk("rst_nc_init_done", nc_init_done, 1'b0);
    chk("port1_tie", {sram_csb1, sram_addr1}, 9'h100);

    // Clear sweep: no grant for cycles 0..255, init_done and grant in cycle 256.
    reset = 1'b0;
    nc_reset = 1'b0;
    gnt_early = 0;
    for (int k = 0; k <= 256; k++) begin
      #1;
      if (k < 256 && m0_gnt) gnt_early++;
      if (k == 0) begin
        chk("nc_init_done_c0", nc_init_done, 1'b0);
        chk("nc_gnt_c0", nc_m0_gnt, 1'b0);
      end
      if (k == 1) begin
        chk("nc_init_done_c1", nc_init_done, 1'b1);
        chk("nc_gnt_c1", nc_m0_gnt, 1'b1);
        chk("init_wr0", {sram_csb0, sram_web0, sram_wmask0, sram_addr0}, {1'b0, 1'b0, 4'hF, 8'h00});
      end
      if (k == 2) chk("init_addr1", sram_addr0, 8'h01);
      if (k == 255) chk("init_done_c255", init_done, 1'b0);
      if (k == 256) begin
        chk("init_done_c256", init_done, 1'b1);
        chk("first_gnt_c256", m0_gnt, 1'b1);
        if (m0_gnt) sb_q.push_back('{0, 32'h0, cyc + 3});
      end
      @(negedge clk);
    end
    m0_req = 1'b0;
    chk("no_gnt_in_init", gnt_early, 0);
    drain();

    // Byte-masked overwrite.
    req1(0, 1'b1, 4'hF, 8'h05, 32'hDEADBEEF, 32'h0);
    req1(0, 1'b1, 4'b0101, 8'h05, 32'h11223344, 32'h0);
    req1(0, 1'b0, 4'h0, 8'h05, 32'h0, 32'hDE22BE44);
    drain();

    // Continuous contention alternates m0, m1, m0, ...
    req1(0, 1'b1, 4'hF, 8'h01, 32'h01010101, 32'h0);
    req1(1, 1'b1, 4'hF, 8'h02, 32'h02020202, 32'h0);
    set_cmd(0, 1'b1, 1'b0, 4'h0, 8'h01, 32'h0);
    set_cmd(1, 1'b1, 1'b0, 4'h0, 8'h02, 32'h0);
    for (int i = 0; i < 6; i++) begin
      #1;
      exp_m = i % 2;
      chk("rr_gnt0", m0_gnt, exp_m == 0);
      chk("rr_gnt1", m1_gnt, exp_m == 1);
      sb_q.push_back('{exp_m, (exp_m == 1) ? 32'h02020202 : 32'h01010101, cyc + 3});
      @(negedge clk);
    end
    m0_req = 1'b0;
    m1_req = 1'b0;
    drain();

    // Read-after-write across requesters, no forwarding.
    set_cmd(1, 1'b1, 1'b1, 4'hF, 8'h20, 32'hCAFEF00D);
    #1;
    chk("raw_wr_gnt", m1_gnt, 1'b1);
    @(negedge clk);
    m1_req = 1'b0;
    set_cmd(0, 1'b1, 1'b0, 4'h0, 8'h20, 32'h0);
    #1;
    chk("raw_rd_gnt", m0_gnt, 1'b1);
    sb_q.push_back('{0, 32'hCAFEF00D, cyc + 3});
    @(negedge clk);
    m0_req = 1'b0;
    drain();

    // Reset with a read in flight: dropped, port deselected, sweep restarts at 0.
    set_cmd(0, 1'b1, 1'b0, 4'h0, 8'h01, 32'h0);
    #1;
    chk("inflight_gnt", m0_gnt, 1'b1);
    @(negedge clk);
    m0_req = 1'b0;
    reset = 1'b1;
    #1;
    chk("inflight_csb0", sram_csb0, 1'b0);
    @(negedge clk);
    chk("csb0_after_reset", sram_csb0, 1'b1);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("reinit_done_c0", init_done, 1'b0);
    @(negedge clk);
    chk("reinit_addr0", {sram_csb0, sram_web0, sram_addr0}, {1'b0, 1'b0, 8'h00});
    @(negedge clk);
    chk("reinit_addr1", sram_addr0, 8'h01);
    for (int i = 0; i < 300 && !init_done; i++) @(negedge clk);
    chk("reinit_done", init_done, 1'b1);
    req1(0, 1'b0, 4'h0, 8'h05, 32'h0, 32'h0);
    req1(1, 1'b0, 4'h0, 8'h20, 32'h0, 32'h0);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
